dmi_access_ctrl: RTL and testbench

Sequences Debug Module Interface (DMI) accesses between the JTAG DTM's `dmi` data register and the debug module's request/response ports. Everything runs in one clock domain. On each DTM update pulse it issues one `dmi_req_t` with a valid/ready handshake, then waits for the matching `dmi_resp_t`. It latches read data for the next capture and maintains the sticky `dmistat` error that `dtmcs` reports.

---
 rtl/dm_pkg.sv | 39 +++
 rtl/dmi_access_ctrl.sv | 131 +++++++++++++
 tb/tb_dmi_access_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Debug module package: DTM op codes, DMI request/response structs, DMI
// access error codes and the DMI access sequencer state encoding.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    DMINoError  = 2'h0,
    DMIReserved = 2'h1,
    DMIOpFailed = 2'h2,
    DMIBusy     = 2'h3
  } dmi_error_e;

  typedef enum logic [2:0] {
    Idle      = 3'd0,
    Read      = 3'd1,
    WaitRead  = 3'd2,
    Write     = 3'd3,
    WaitWrite = 3'd4
  } dmi_state_e;

endpackage

// File: rtl/dmi_access_ctrl.sv
// DMI access sequencer between the DTM dmi data register and the debug module.
// Handshakes: a request is offered with dmi_req_valid_o and completes in the
// cycle where dmi_req_ready_i is also high; once raised, valid and the request
// payload stay stable until that cycle (dmihardreset_i is the only withdrawal).
// A response completes in the cycle where dmi_resp_valid_i and
// dmi_resp_ready_o are both high.
module dmi_access_ctrl
  import dm::*;
#(
  parameter int unsigned ABITS = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             update_i,
  input  logic             capture_i,
  input  logic [ABITS+33:0] dr_req_i,
  output logic [ABITS+33:0] dr_o,
  output logic [1:0]       dmistat_o,
  input  logic             dmireset_i,
  input  logic             dmihardreset_i,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output dmi_req_t         dmi_req_o,
  input  logic             dmi_resp_valid_i,
  output logic             dmi_resp_ready_o,
  input  dmi_resp_t        dmi_resp_i,
  output dmi_state_e       state_o
);

  dmi_state_e           state_q, state_d;
  dmi_error_e           dmistat_q, dmistat_d;
  logic [ABITS-1:0]     addr_q;
  dtm_op_e              op_q;
  logic [31:0]          wdata_q;
  logic [31:0]          data_q;
  logic [ABITS+33:0]    dr_q;

  logic [ABITS-1:0]     dr_addr;
  logic [31:0]          dr_data;
  dtm_op_e              dr_op;
  logic                 busy;
  logic                 accept;
  logic                 in_wait;
  logic                 err_op;
  logic                 err_busy;

  assign dr_addr  = dr_req_i[ABITS+33:34];
  assign dr_data  = dr_req_i[33:2];
  assign dr_op    = dtm_op_e'(dr_req_i[1:0]);

  assign busy     = (state_q != Idle);
  assign in_wait  = (state_q == WaitRead) || (state_q == WaitWrite);
  // A new access is taken only from Idle with no sticky error outstanding.
  assign accept   = (state_q == Idle) && update_i && (dmistat_q == DMINoError)
                    && !dmihardreset_i;
  assign err_op   = in_wait && dmi_resp_valid_i && (dmi_resp_i.resp != DTM_SUCCESS);
  assign err_busy = busy && (update_i || capture_i);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= Idle;
    else       state_q <= state_d;
  end

  // Next-state logic; hard reset overrides every other input.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Idle: begin
        if (accept) begin
          if (dr_op == DTM_READ)       state_d = Read;
          else if (dr_op == DTM_WRITE) state_d = Write;
        end
      end
      Read:      if (dmi_req_ready_i)  state_d = WaitRead;
      Write:     if (dmi_req_ready_i)  state_d = WaitWrite;
      WaitRead:  if (dmi_resp_valid_i) state_d = Idle;
      WaitWrite: if (dmi_resp_valid_i) state_d = Idle;
      default:                         state_d = Idle;
    endcase
    if (dmihardreset_i) state_d = Idle;
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    dmi_req_valid_o  = (state_q == Read) || (state_q == Write);
    dmi_resp_ready_o = !((state_q == Read) || (state_q == Write));
    dmi_req_o.addr   = addr_q;
    dmi_req_o.op     = op_q;
    dmi_req_o.data   = wdata_q;
  end

  // Sticky error: first error wins; a new error beats a coincident dmireset.
  always_comb begin
    dmistat_d = dmistat_q;
    if (dmireset_i) dmistat_d = DMINoError;
    if ((dmistat_q == DMINoError) || dmireset_i) begin
      if (err_op)        dmistat_d = DMIOpFailed;
      else if (err_busy) dmistat_d = DMIBusy;
    end
    if (dmihardreset_i) dmistat_d = DMINoError;
  end

  // Request latches, read data, error register and capture register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      op_q      <= DTM_NOP;
      wdata_q   <= '0;
      data_q    <= '0;
      dmistat_q <= DMINoError;
      dr_q      <= '0;
    end else begin
      dmistat_q <= dmistat_d;
      if (accept) begin
        addr_q  <= dr_addr;
        op_q    <= dr_op;
        wdata_q <= dr_data;
      end
      if ((state_q == WaitRead) && dmi_resp_valid_i && !dmihardreset_i)
        data_q <= dmi_resp_i.data;
      if (capture_i)
        dr_q <= {addr_q, data_q, dmistat_d};
    end
  end

  assign dr_o      = dr_q;
  assign dmistat_o = dmistat_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Directed bench for dmi_access_ctrl: one task per scenario.
module tb_dmi_access_ctrl;
  import dm::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        update_i = 1'b0;
  logic        capture_i = 1'b0;
  logic [40:0] dr_req_i = '0;
  logic [40:0] dr_o;
  logic [1:0]  dmistat_o;
  logic        dmireset_i = 1'b0;
  logic        dmihardreset_i = 1'b0;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i = 1'b0;
  dmi_req_t    dmi_req_o;
  logic        dmi_resp_valid_i = 1'b0;
  logic        dmi_resp_ready_o;
  dmi_resp_t   dmi_resp_i = '0;
  dmi_state_e  state_o;

  int checks = 0;
  int errors = 0;

  dmi_access_ctrl #(.ABITS(7)) dut (
    .clk_i(clk), .rst_i(rst), .update_i(update_i), .capture_i(capture_i),
    .dr_req_i(dr_req_i), .dr_o(dr_o), .dmistat_o(dmistat_o),
    .dmireset_i(dmireset_i), .dmihardreset_i(dmihardreset_i),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_req_o(dmi_req_o), .dmi_resp_valid_i(dmi_resp_valid_i),
    .dmi_resp_ready_o(dmi_resp_ready_o), .dmi_resp_i(dmi_resp_i),
    .state_o(state_o)
  );

  // Clock generation
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    dr_req_i = {a, d, op};
    update_i = 1'b1;
    tick();
    update_i = 1'b0;
  endtask

  task automatic do_capture();
    capture_i = 1'b1;
    tick();
    capture_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] r);
    dmi_resp_i = '{data: d, resp: r};
    dmi_resp_valid_i = 1'b1;
    tick();
    dmi_resp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (dmi_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dmi_req_valid_o); end
    checks++; if (dmi_resp_ready_o !== 1'b1) begin errors++; $display("FAIL reset_resp_ready got %b exp 1", dmi_resp_ready_o); end
    checks++; if (dr_o !== 41'h0) begin errors++; $display("FAIL reset_dr got %h exp 0", dr_o); end
    checks++; if (dmistat_o !== 2'd0) begin errors++; $display("FAIL reset_dmistat got %0d exp 0", dmistat_o); end
    checks++; if (state_o !== Idle) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
  endtask

  task automatic test_read();
    do_update(7'h11, 32'h0, 2'd1);
    checks++; if (dmi_req_valid_o !== 1'b1) begin errors++; $display("FAIL read_valid got %b exp 1", dmi_req_valid_o); end
    checks++; if (dmi_req_o !== {7'h11, 2'd1, 32'h0}) begin errors++; $display("FAIL read_req got %h exp %h", dmi_req_o, {7'h11, 2'd1, 32'h0}); end
    checks++; if (dmi_resp_ready_o !== 1'b0) begin errors++; $display("FAIL read_resp_ready_in_req got %b exp 0", dmi_resp_ready_o); end
    dmi_req_ready_i = 1'b1;
    tick();
    dmi_req_ready_i = 1'b0;
    checks++; if (state_o !== WaitRead) begin errors++; $display("FAIL read_waitstate got %0d exp 2", state_o); end
    checks++; if (dmi_req_valid_o !== 1'b0) begin errors++; $display("FAIL read_valid_drop got %b exp 0", dmi_req_valid_o); end
    respond(32'hDEADBEEF, 2'd0);
    checks++; if (state_o !== Idle) begin errors++; $display("FAIL read_idle got %0d exp 0", state_o); end
    do_capture();
    checks++; if (dr_o !== {7'h11, 32'hDEADBEEF, 2'd0}) begin errors++; $display("FAIL read_capture got %h exp %h", dr_o, {7'h11, 32'hDEADBEEF, 2'd0}); end
  endtask

  task automatic test_write_stall();
    int hs;
    hs = 0;
    do_update(7'h10, 32'h0000_0001, 2'd2);
    for (int i = 0; i < 5; i++) begin
      checks++; if (dmi_req_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, dmi_req_valid_o); end
      checks++; if (dmi_req_o !== {7'h10, 2'd2, 32'h1}) begin errors++; $display("FAIL stall_req[%0d] got %h exp %h", i, dmi_req_o, {7'h10, 2'd2, 32'h1}); end
      if (dmi_req_valid_o && dmi_req_ready_i) hs++;
      tick();
    end
    dmi_req_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (dmi_req_valid_o && dmi_req_ready_i) hs++;
      tick();
    end
    dmi_req_ready_i = 1'b0;
    checks++; if (hs !== 1) begin errors++; $display("FAIL stall_handshakes got %0d exp 1", hs); end
    checks++; if (state_o !== WaitWrite) begin errors++; $display("FAIL stall_waitwrite got %0d exp 4", state_o); end
    respond(32'hFFFF_FFFF, 2'd0);
    checks++; if (dmistat_o !== 2'd0) begin errors++; $display("FAIL write_dmistat got %0d exp 0", dmistat_o); end
    do_capture();
    checks++; if (dr_o !== {7'h10, 32'hDEADBEEF, 2'd0}) begin errors++; $display("FAIL write_capture got %h exp %h", dr_o, {7'h10, 32'hDEADBEEF, 2'd0}); end
  endtask

  task automatic test_busy();
    do_update(7'h05, 32'h0, 2'd1);
    dmi_req_ready_i = 1'b1;
    tick();
    dmi_req_ready_i = 1'b0;
    do_capture();
    checks++; if (dr_o !== {7'h05, 32'hDEADBEEF, 2'd3}) begin errors++; $display("FAIL busy_capture got %h exp %h", dr_o, {7'h05, 32'hDEADBEEF, 2'd3}); end
    checks++; if (dmistat_o !== 2'd3) begin errors++; $display("FAIL busy_dmistat got %0d exp 3", dmistat_o); end
    respond(32'h12345678, 2'd0);
    do_update(7'h06, 32'h0, 2'd1);
    checks++; if (dmi_req_valid_o !== 1'b0) begin errors++; $display("FAIL busy_ignored_valid got %b exp 0", dmi_req_valid_o); end
    tick();
    checks++; if (state_o !== Idle) begin errors++; $display("FAIL busy_ignored_state got %0d exp 0", state_o); end
    dmireset_i = 1'b1;
    tick();
    dmireset_i = 1'b0;
    checks++; if (dmistat_o !== 2'd0) begin errors++; $display("FAIL dmireset_clear got %0d exp 0", dmistat_o); end
    do_capture();
    checks++; if (dr_o !== {7'h05, 32'h12345678, 2'd0}) begin errors++; $display("FAIL busy_addr_kept got %h exp %h", dr_o, {7'h05, 32'h12345678, 2'd0}); end
    do_update(7'h06, 32'h0, 2'd1);
    checks++; if (dmi_req_o !== {7'h06, 2'd1, 32'h0} || dmi_req_valid_o !== 1'b1) begin errors++; $display("FAIL resume_req got %h/%b exp %h/1", dmi_req_o, dmi_req_valid_o, {7'h06, 2'd1, 32'h0}); end
    dmi_req_ready_i = 1'b1;
    tick();
    dmi_req_ready_i = 1'b0;
    respond(32'hCAFEF00D, 2'd0);
  endtask

  task automatic test_op_failed();
    do_update(7'h20, 32'hA5A5A5A5, 2'd2);
    dmi_req_ready_i = 1'b1;
    tick();
    dmi_req_ready_i = 1'b0;
    respond(32'h0, 2'd2);
    checks++; if (dmistat_o !== 2'd2) begin errors++; $display("FAIL opfail_dmistat got %0d exp 2", dmistat_o); end
    do_update(7'h21, 32'h0, 2'd1);
    do_capture();
    checks++; if (dmistat_o !== 2'd2) begin errors++; $display("FAIL opfail_sticky got %0d exp 2", dmistat_o); end
    checks++; if (dr_o !== {7'h20, 32'hCAFEF00D, 2'd2}) begin errors++; $display("FAIL opfail_capture got %h exp %h", dr_o, {7'h20, 32'hCAFEF00D, 2'd2}); end
    dmireset_i = 1'b1;
    tick();
    dmireset_i = 1'b0;
  endtask

  task automatic test_hardreset();
    do_update(7'h30, 32'h55, 2'd2);
    checks++; if (dmi_req_valid_o !== 1'b1) begin errors++; $display("FAIL hr_valid_before got %b exp 1", dmi_req_valid_o); end
    dmihardreset_i = 1'b1;
    tick();
    dmihardreset_i = 1'b0;
    checks++; if (dmi_req_valid_o !== 1'b0) begin errors++; $display("FAIL hr_valid_drop got %b exp 0", dmi_req_valid_o); end
    checks++; if (state_o !== Idle) begin errors++; $display("FAIL hr_state got %0d exp 0", state_o); end
    respond(32'hBAD0BAD0, 2'd2);
    checks++; if (dmistat_o !== 2'd0) begin errors++; $display("FAIL hr_late_resp_stat got %0d exp 0", dmistat_o); end
    do_capture();
    checks++; if (dr_o !== {7'h30, 32'hCAFEF00D, 2'd0}) begin errors++; $display("FAIL hr_capture got %h exp %h", dr_o, {7'h30, 32'hCAFEF00D, 2'd0}); end
  endtask

  task automatic test_async_reset();
    do_update(7'h40, 32'h0, 2'd1);
    dmi_req_ready_i = 1'b1;
    tick();
    dmi_req_ready_i = 1'b0;
    do_capture();
    checks++; if (dmistat_o !== 2'd3) begin errors++; $display("FAIL ar_pre_dmistat got %0d exp 3", dmistat_o); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (dr_o !== 41'h0) begin errors++; $display("FAIL ar_dr got %h exp 0", dr_o); end
    checks++; if (dmistat_o !== 2'd0) begin errors++; $display("FAIL ar_dmistat got %0d exp 0", dmistat_o); end
    checks++; if (state_o !== Idle) begin errors++; $display("FAIL ar_state got %0d exp 0", state_o); end
    checks++; if (dmi_req_valid_o !== 1'b0 || dmi_resp_ready_o !== 1'b1) begin errors++; $display("FAIL ar_handshake got %b/%b exp 0/1", dmi_req_valid_o, dmi_resp_ready_o); end
    tick();
    rst = 1'b0;
    tick();
    do_capture();
    checks++; if (dr_o !== 41'h0) begin errors++; $display("FAIL ar_capture_after got %h exp 0", dr_o); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_stall();
    test_busy();
    test_op_failed();
    test_hardreset();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
